mw_add_ctrl: RTL and testbench

MW_ADD_CTRL -- requirements
Module: mw_add_ctrl

---
 rtl/mw_add_ctrl_pkg.sv | 27 ++
 rtl/mw_add_defs.vh | 17 +
 rtl/r16_adder.sv | 18 +
 rtl/mw_add_ctrl.sv | 155 +++++++++++++++
 tb/tb_mw_add_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mw_add_ctrl_pkg.sv
`include "mw_add_defs.vh"
`default_nettype none
// ============================================================================
//  Module      : mw_add_ctrl_pkg
//  Description : Types and helpers shared by the multi-word adder controller.
//  Revision    : 1.0
// ============================================================================
package mw_add_ctrl_pkg;

  localparam int WORD_W = `MW_WORD_W;

  typedef enum logic [1:0] {
    ST_IDLE = `MW_ST_IDLE,
    ST_RUN  = `MW_ST_RUN,
    ST_DONE = `MW_ST_DONE
  } state_e;

  // Round-robin pick: on a tie the requester not granted last wins.
  function automatic logic rr_pick(input logic req0, input logic req1,
                                   input logic last);
    if (req0 && req1) return ~last;
    else if (req1)    return 1'b1;
    else              return 1'b0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mw_add_defs.vh
`default_nettype none
// ============================================================================
//  File        : mw_add_defs.vh
//  Description : Shared state encodings and slice width for the multi-word
//                adder controller.
//  Revision    : 1.0
// ============================================================================
`ifndef MW_ADD_DEFS_VH
`define MW_ADD_DEFS_VH

`define MW_ST_IDLE 2'd0
`define MW_ST_RUN  2'd1
`define MW_ST_DONE 2'd2
`define MW_WORD_W  16

`endif
`default_nettype wire

// File: rtl/r16_adder.sv
`default_nettype none
// ============================================================================
//  Module      : r16_adder
//  Description : 16-bit ripple adder slice with carry-in and carry-out.
//  Revision    : 1.0
// ============================================================================
module r16_adder (
  output logic [15:0] Y,
  output logic        Cout,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin
);

  assign {Cout, Y} = {1'b0, A} + {1'b0, B} + {16'b0, Cin};

endmodule
`default_nettype wire

// File: rtl/mw_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mw_add_ctrl
//  Description : Two-requester, round-robin arbitrated multi-word adder that
//                time-shares a single 16-bit slice, LSW first.
//  Revision    : 1.0
// ============================================================================
module mw_add_ctrl
  import mw_add_ctrl_pkg::*;
#(
  parameter int NW = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic               req1,
  input  logic [16*NW-1:0]   a0,
  input  logic [16*NW-1:0]   b0,
  input  logic [16*NW-1:0]   a1,
  input  logic [16*NW-1:0]   b1,
  input  logic               ci0,
  input  logic               ci1,
  output logic               ack0,
  output logic               ack1,
  output logic [16*NW-1:0]   sum,
  output logic               cout,
  output logic               done,
  output logic               done_id,
  output logic               busy
);

  localparam int W  = WORD_W * NW;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [IW-1:0] C_LAST_IDX = IW'(NW - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [IW-1:0]     r_idx;
  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic              r_carry;
  logic              r_last;
  logic              r_id;
  logic [W-1:0]      r_sum;
  logic              r_cout;
  logic              r_done;
  logic              r_done_id;
  logic              r_ack0;
  logic              r_ack1;

  logic              w_grant;
  logic              w_win;
  logic [WORD_W-1:0] w_op_a;
  logic [WORD_W-1:0] w_op_b;
  logic [WORD_W-1:0] w_slice_y;
  logic              w_slice_co;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode and grant decision.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_win       = rr_pick(req0, req1, r_last);
    case (r_state)
      ST_IDLE: begin
        if (req0 || req1) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN:  if (r_idx == C_LAST_IDX) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Select the operand word addressed by the current word index.
  always_comb begin
    w_op_a = '0;
    w_op_b = '0;
    for (int k = 0; k < NW; k++) begin
      if (r_idx == IW'(k)) begin
        w_op_a = r_a[k*WORD_W +: WORD_W];
        w_op_b = r_b[k*WORD_W +: WORD_W];
      end
    end
  end

  r16_adder u_slice (
    .Y    (w_slice_y),
    .Cout (w_slice_co),
    .A    (w_op_a),
    .B    (w_op_b),
    .Cin  (r_carry)
  );

  // Operand capture, word-serial accumulation and result/handshake pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_carry   <= 1'b0;
      r_last    <= 1'b1;
      r_id      <= 1'b0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= 1'b0;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      r_done <= 1'b0;
      if (w_grant) begin
        r_a     <= w_win ? a1  : a0;
        r_b     <= w_win ? b1  : b0;
        r_carry <= w_win ? ci1 : ci0;
        r_idx   <= '0;
        r_id    <= w_win;
        r_last  <= w_win;
        r_ack0  <= ~w_win;
        r_ack1  <= w_win;
      end
      if (r_state == ST_RUN) begin
        for (int k = 0; k < NW; k++) begin
          if (r_idx == IW'(k)) r_sum[k*WORD_W +: WORD_W] <= w_slice_y;
        end
        r_carry <= w_slice_co;
        r_cout  <= w_slice_co;
        r_idx   <= r_idx + 1'b1;
      end
      if (r_state == ST_DONE) begin
        r_done    <= 1'b1;
        r_done_id <= r_id;
      end
    end
  end

  assign ack0    = r_ack0;
  assign ack1    = r_ack1;
  assign sum     = r_sum;
  assign cout    = r_cout;
  assign done    = r_done;
  assign done_id = r_done_id;
  assign busy    = (r_state == ST_RUN) || (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_mw_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mw_add_ctrl
//  Description : Directed self-checking bench for mw_add_ctrl (NW=4 and NW=1).
//  Revision    : 1.0
// ============================================================================
module tb_mw_add_ctrl;

  localparam int NW = 4;
  localparam int W  = 16 * NW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, req0, req1, ci0, ci1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         ack0, ack1, cout, done, done_id, busy;
  logic [W-1:0] sum;

  logic         req0_s, ci0_s;
  logic [15:0]  a0_s, b0_s;
  logic         ack0_s, ack1_s, cout_s, done_s, done_id_s, busy_s;
  logic [15:0]  sum_s;
  logic         req1_s = 1'b0;
  logic         ci1_s  = 1'b0;
  logic [15:0]  a1_s   = 16'h0;
  logic [15:0]  b1_s   = 16'h0;

  int n_chk  = 0;
  int n_pass = 0;

  mw_add_ctrl #(.NW(NW)) u_dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .ci0(ci0), .ci1(ci1),
    .ack0(ack0), .ack1(ack1), .sum(sum), .cout(cout),
    .done(done), .done_id(done_id), .busy(busy)
  );

  mw_add_ctrl #(.NW(1)) u_dut1 (
    .clk(clk), .rst(rst), .req0(req0_s), .req1(req1_s),
    .a0(a0_s), .b0(b0_s), .a1(a1_s), .b1(b1_s), .ci0(ci0_s), .ci1(ci1_s),
    .ack0(ack0_s), .ack1(ack1_s), .sum(sum_s), .cout(cout_s),
    .done(done_s), .done_id(done_id_s), .busy(busy_s)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; req0 = 1'b1; a0 = 64'h5; b0 = 64'h5;
    tick(); tick();
    n_chk++; if (ack0 !== 1'b0) $display("FAIL reset_ack0: got %b want 0", ack0); else n_pass++;
    n_chk++; if (ack1 !== 1'b0) $display("FAIL reset_ack1: got %b want 0", ack1); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_chk++; if (sum !== 64'h0) $display("FAIL reset_sum: got %h want 0", sum); else n_pass++;
    n_chk++; if (cout !== 1'b0) $display("FAIL reset_cout: got %b want 0", cout); else n_pass++;
    n_chk++; if (done_id !== 1'b0) $display("FAIL reset_done_id: got %b want 0", done_id); else n_pass++;
    n_chk++; if (busy_s !== 1'b0) $display("FAIL reset_busy_nw1: got %b want 0", busy_s); else n_pass++;
    req0 = 1'b0; rst = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    int cnt;
    a0 = 64'hFFFF_FFFF_FFFF_FFFF; b0 = 64'h1; ci0 = 1'b0; req0 = 1'b1;
    tick();
    n_chk++; if (ack0 !== 1'b1) $display("FAIL basic_ack0: got %b want 1", ack0); else n_pass++;
    n_chk++; if (ack1 !== 1'b0) $display("FAIL basic_ack1: got %b want 0", ack1); else n_pass++;
    n_chk++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else n_pass++;
    req0 = 1'b0;
    a0 = 64'h1234_5678_9ABC_DEF0; b0 = 64'h5555_5555_5555_5555; ci0 = 1'b1;
    cnt = 0;
    while (done !== 1'b1 && cnt < 20) begin
      tick(); cnt++;
      if (cnt == 1) begin
        n_chk++; if (ack0 !== 1'b0) $display("FAIL basic_ack0_pulse: got %b want 0", ack0); else n_pass++;
      end
    end
    n_chk++; if (cnt !== NW + 1) $display("FAIL basic_latency: got %0d want %0d", cnt, NW + 1); else n_pass++;
    n_chk++; if (sum !== 64'h0) $display("FAIL basic_sum: got %h want 0", sum); else n_pass++;
    n_chk++; if (cout !== 1'b1) $display("FAIL basic_cout: got %b want 1", cout); else n_pass++;
    n_chk++; if (done_id !== 1'b0) $display("FAIL basic_done_id: got %b want 0", done_id); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL basic_busy_end: got %b want 0", busy); else n_pass++;
    tick();
    n_chk++; if (done !== 1'b0) $display("FAIL basic_done_pulse: got %b want 0", done); else n_pass++;
    n_chk++; if (sum !== 64'h0) $display("FAIL basic_sum_hold: got %h want 0", sum); else n_pass++;
  endtask

  task automatic test_carry_in;
    int cnt;
    a0 = 64'h0000_FFFF_0000_FFFF; b0 = 64'h1; ci0 = 1'b1; req0 = 1'b1;
    tick();
    req0 = 1'b0;
    cnt = 0;
    while (done !== 1'b1 && cnt < 20) begin tick(); cnt++; end
    n_chk++; if (cnt !== NW + 1) $display("FAIL cin_latency: got %0d want %0d", cnt, NW + 1); else n_pass++;
    n_chk++; if (sum !== 64'h0000_FFFF_0001_0001) $display("FAIL cin_sum: got %h want 0000ffff00010001", sum); else n_pass++;
    n_chk++; if (cout !== 1'b0) $display("FAIL cin_cout: got %b want 0", cout); else n_pass++;
    tick();
  endtask

  task automatic test_req1;
    logic [W-1:0] va [2];
    logic [W-1:0] vb [2];
    logic         vc [2];
    logic [W-1:0] es [2];
    logic         ec [2];
    int cnt;
    va[0] = 64'h1234_5678_9ABC_DEF0; vb[0] = 64'h1111_1111_1111_1111; vc[0] = 1'b0;
    es[0] = 64'h2345_6789_ABCD_F001; ec[0] = 1'b0;
    va[1] = 64'hFFFF_FFFF_FFFF_FFFF; vb[1] = 64'hFFFF_FFFF_FFFF_FFFF; vc[1] = 1'b1;
    es[1] = 64'hFFFF_FFFF_FFFF_FFFF; ec[1] = 1'b1;
    for (int v = 0; v < 2; v++) begin
      a1 = va[v]; b1 = vb[v]; ci1 = vc[v]; req1 = 1'b1;
      tick();
      n_chk++; if (ack1 !== 1'b1) $display("FAIL req1_ack1[%0d]: got %b want 1", v, ack1); else n_pass++;
      n_chk++; if (ack0 !== 1'b0) $display("FAIL req1_ack0[%0d]: got %b want 0", v, ack0); else n_pass++;
      req1 = 1'b0;
      cnt = 0;
      while (done !== 1'b1 && cnt < 20) begin tick(); cnt++; end
      n_chk++; if (cnt !== NW + 1) $display("FAIL req1_latency[%0d]: got %0d want %0d", v, cnt, NW + 1); else n_pass++;
      n_chk++; if (sum !== es[v]) $display("FAIL req1_sum[%0d]: got %h want %h", v, sum, es[v]); else n_pass++;
      n_chk++; if (cout !== ec[v]) $display("FAIL req1_cout[%0d]: got %b want %b", v, cout, ec[v]); else n_pass++;
      n_chk++; if (done_id !== 1'b1) $display("FAIL req1_done_id[%0d]: got %b want 1", v, done_id); else n_pass++;
      tick();
    end
  endtask

  task automatic test_tie;
    int cnt;
    logic got0;
    rst = 1'b1; tick(); rst = 1'b0; tick();
    a0 = 64'd1; b0 = 64'd2; ci0 = 1'b0;
    a1 = 64'd10; b1 = 64'd20; ci1 = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    tick();
    n_chk++; if (ack0 !== 1'b1) $display("FAIL tie_ack0: got %b want 1", ack0); else n_pass++;
    n_chk++; if (ack1 !== 1'b0) $display("FAIL tie_ack1_first: got %b want 0", ack1); else n_pass++;
    req0 = 1'b0;
    cnt = 0; got0 = 1'b0;
    while (ack1 !== 1'b1 && cnt < 30) begin
      tick(); cnt++;
      if (done === 1'b1) begin
        got0 = 1'b1;
        n_chk++; if (done_id !== 1'b0) $display("FAIL tie_done_id0: got %b want 0", done_id); else n_pass++;
        n_chk++; if (sum !== 64'd3) $display("FAIL tie_sum0: got %h want 3", sum); else n_pass++;
      end
    end
    n_chk++; if (got0 !== 1'b1) $display("FAIL tie_first_done: got %b want 1", got0); else n_pass++;
    n_chk++; if (cnt !== NW + 2) $display("FAIL tie_ack_spacing: got %0d want %0d", cnt, NW + 2); else n_pass++;
    req1 = 1'b0;
    cnt = 0;
    while (done !== 1'b1 && cnt < 20) begin tick(); cnt++; end
    n_chk++; if (done_id !== 1'b1) $display("FAIL tie_done_id1: got %b want 1", done_id); else n_pass++;
    n_chk++; if (sum !== 64'd30) $display("FAIL tie_sum1: got %h want 1e", sum); else n_pass++;
    tick();
  endtask

  task automatic test_alternate;
    int g [4];
    int n, cyc, both;
    rst = 1'b1; tick(); rst = 1'b0; tick();
    a0 = 64'd7; b0 = 64'd8; a1 = 64'd9; b1 = 64'd6; ci0 = 1'b0; ci1 = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    n = 0; cyc = 0; both = 0;
    while (n < 4 && cyc < 60) begin
      tick(); cyc++;
      if (ack0 === 1'b1 && ack1 === 1'b1) both++;
      if (ack0 === 1'b1) begin g[n] = 0; n++; end
      else if (ack1 === 1'b1) begin g[n] = 1; n++; end
    end
    req0 = 1'b0; req1 = 1'b0;
    n_chk++; if (n !== 4) $display("FAIL alt_grant_count: got %0d want 4", n); else n_pass++;
    n_chk++; if (both !== 0) $display("FAIL alt_dual_ack: got %0d want 0", both); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      if (i < n) begin
        n_chk++; if (g[i] !== (i % 2)) $display("FAIL alt_grant[%0d]: got %0d want %0d", i, g[i], i % 2); else n_pass++;
      end
    end
    cyc = 0;
    while (busy === 1'b1 && cyc < 20) begin tick(); cyc++; end
    tick();
  endtask

  task automatic test_reset_abort;
    int seen;
    a0 = 64'h0001_0002_0003_0004; b0 = 64'h0010_0020_0030_0040; ci0 = 1'b0;
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    tick(); tick();
    n_chk++; if (sum !== 64'h0000_0000_0033_0044) $display("FAIL abort_partial_sum: got %h want 0000000000330044", sum); else n_pass++;
    n_chk++; if (busy !== 1'b1) $display("FAIL abort_busy_before: got %b want 1", busy); else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (sum !== 64'h0) $display("FAIL abort_sum: got %h want 0", sum); else n_pass++;
    n_chk++; if (cout !== 1'b0) $display("FAIL abort_cout: got %b want 0", cout); else n_pass++;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1) seen++;
      tick();
    end
    n_chk++; if (seen !== 0) $display("FAIL abort_no_done: got %0d pulses want 0", seen); else n_pass++;
  endtask

  task automatic test_nw1;
    int cnt;
    a0_s = 16'hFFFF; b0_s = 16'h0001; ci0_s = 1'b0; req0_s = 1'b1;
    tick();
    n_chk++; if (ack0_s !== 1'b1) $display("FAIL nw1_ack0: got %b want 1", ack0_s); else n_pass++;
    req0_s = 1'b0;
    cnt = 0;
    while (done_s !== 1'b1 && cnt < 20) begin tick(); cnt++; end
    n_chk++; if (cnt !== 2) $display("FAIL nw1_latency: got %0d want 2", cnt); else n_pass++;
    n_chk++; if (sum_s !== 16'h0) $display("FAIL nw1_sum: got %h want 0", sum_s); else n_pass++;
    n_chk++; if (cout_s !== 1'b1) $display("FAIL nw1_cout: got %b want 1", cout_s); else n_pass++;
    n_chk++; if (done_id_s !== 1'b0) $display("FAIL nw1_done_id: got %b want 0", done_id_s); else n_pass++;
    tick();
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; ci0 = 1'b0; ci1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    req0_s = 1'b0; ci0_s = 1'b0; a0_s = '0; b0_s = '0;
    test_reset();
    test_basic();
    test_carry_in();
    test_req1();
    test_tie();
    test_alternate();
    test_reset_abort();
    test_nw1();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
